sram_responder: RTL and testbench

Synchronous, cycle-level model of the board's asynchronous 16-bit SRAM, sitting on the far side of the external memory bus (`memDataBus`, `memAddrBus`, `memRead`, `memWrite`, `memEnable`) that the memory controller drives. It answers reads, commits writes, and checks the controller's bus protocol. It lets the memory controller run in simulation and in FPGA loopback builds without the physical chip. It also exposes access counters and sticky protocol-error flags for the debug LEDs.

---
 rtl/sram_bus_pkg.sv | 19 +
 rtl/sram_storage.sv | 32 +++
 rtl/sram_responder.sv | 133 +++++++++++++
 tb/tb_sram_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the cycle-level SRAM bus responder.
package sram_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } busStateT;

    localparam int ERR_CONTENTION    = 0;
    localparam int ERR_ADDR_UNSTABLE = 1;
    localparam int ERR_RANGE         = 2;

    // The SRAM control strobes are all active-low.
    localparam logic CE_ACTIVE = 1'b0;
    localparam logic OE_ACTIVE = 1'b0;
    localparam logic WE_ACTIVE = 1'b0;

endpackage

// File: rtl/sram_storage.sv
// Single-port synchronous RAM with a registered read port; maps onto block RAM.
module sram_storage #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writeEn,
    input  logic                  readEn,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Array contents survive reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[addr] <= writeData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            readData <= '0;
        end else if (readEn) begin
            readData <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Cycle-level stand-in for the external asynchronous SRAM: answers reads,
// commits writes, counts accesses and flags controller protocol errors.
//   state | meaning
//   IDLE  | bus released, no access in progress
//   READ  | driving dout onto memDataBus, reloaded each cycle rd is held
//   WRITE | capturing addr/data; commit on the first edge wr is false
module sram_responder
    import sram_bus_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [DATA_WIDTH-1:0] memDataBus,
    input  logic [ADDR_WIDTH-1:0] memAddrBus,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic                  memEnable,
    output logic [15:0]           readCount,
    output logic [15:0]           writeCount,
    output logic [2:0]            errorFlags
);

    busStateT              state, nextState;
    logic [ADDR_WIDTH-1:0] capAddr;
    logic [DATA_WIDTH-1:0] capData;
    logic [DATA_WIDTH-1:0] dout;
    logic                  chipOn, rd, wr, contention, outOfRange;
    logic                  loadRead, capture, commit, readDone;

    assign chipOn     = (memEnable == CE_ACTIVE);
    assign wr         = chipOn && (memWrite == WE_ACTIVE);
    assign rd         = chipOn && (memRead == OE_ACTIVE) && (memWrite != WE_ACTIVE);
    assign contention = chipOn && (memRead == OE_ACTIVE) && (memWrite == WE_ACTIVE);
    assign outOfRange = |memAddrBus[ADDR_WIDTH-1:DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        loadRead  = 1'b0;
        capture   = 1'b0;
        commit    = 1'b0;
        readDone  = 1'b0;
        case (state)
            IDLE: begin
                if (wr) begin
                    nextState = WRITE;
                    capture   = 1'b1;
                end else if (rd) begin
                    nextState = READ;
                    loadRead  = 1'b1;
                end
            end
            READ: begin
                if (wr) begin
                    nextState = WRITE;
                    capture   = 1'b1;
                end else if (rd) begin
                    loadRead  = 1'b1;
                end else begin
                    nextState = IDLE;
                    readDone  = 1'b1;
                end
            end
            WRITE: begin
                // A pending rd waits one edge: the port is busy committing.
                if (wr) begin
                    capture   = 1'b1;
                end else begin
                    nextState = IDLE;
                    commit    = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            capAddr <= memAddrBus;
            capData <= memDataBus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            readCount  <= '0;
            writeCount <= '0;
            errorFlags <= '0;
        end else begin
            if (readDone && readCount != 16'hFFFF) begin
                readCount <= readCount + 16'd1;
            end
            if (commit && writeCount != 16'hFFFF) begin
                writeCount <= writeCount + 16'd1;
            end
            if (contention) begin
                errorFlags[ERR_CONTENTION] <= 1'b1;
            end
            if (state == WRITE && wr && memAddrBus != capAddr) begin
                errorFlags[ERR_ADDR_UNSTABLE] <= 1'b1;
            end
            if ((rd || wr) && outOfRange) begin
                errorFlags[ERR_RANGE] <= 1'b1;
            end
        end
    end

    sram_storage #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) uStorage (
        .clk       (clk),
        .rst       (rst),
        .writeEn   (commit && !rst),
        .readEn    (loadRead),
        .addr      (commit ? capAddr[DEPTH_LOG2-1:0] : memAddrBus[DEPTH_LOG2-1:0]),
        .writeData (capData),
        .readData  (dout)
    );

    assign memDataBus = (state == READ) ? dout : 'z;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboarded bench for sram_responder; the bus is pulled high so a released
// bus reads as all ones.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] memAddrBus;
    logic        memRead, memWrite, memEnable;
    logic        tbDrive;
    logic [15:0] tbData;
    tri1  [15:0] memDataBus;
    logic [15:0] readCount, writeCount;
    logic [2:0]  errorFlags;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [15:0] model [0:1023];
    logic [15:0] expQ [$];

    always #5 clk = ~clk;

    assign memDataBus = tbDrive ? tbData : 'z;

    sram_responder dut (
        .clk        (clk),
        .rst        (rst),
        .memDataBus (memDataBus),
        .memAddrBus (memAddrBus),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .memEnable  (memEnable),
        .readCount  (readCount),
        .writeCount (writeCount),
        .errorFlags (errorFlags)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic busIdle();
        memEnable = 1'b1;
        memRead   = 1'b1;
        memWrite  = 1'b1;
        tbDrive   = 1'b0;
    endtask

    task automatic idleCycle();
        @(negedge clk);
        busIdle();
        @(posedge clk);
        #1;
    endtask

    task automatic driveWrite(input logic [17:0] a, input logic [15:0] d);
        @(negedge clk);
        memEnable  = 1'b0;
        memWrite   = 1'b0;
        memRead    = 1'b1;
        memAddrBus = a;
        tbData     = d;
        tbDrive    = 1'b1;
        @(posedge clk);
    endtask

    task automatic writeWord(input logic [17:0] a, input logic [15:0] d, input int cycles);
        for (int i = 0; i < cycles; i++) driveWrite(a, d);
        idleCycle();
        model[a[9:0]] = d;
    endtask

    task automatic readCycle(input logic [17:0] a);
        logic [15:0] exp;
        @(negedge clk);
        memEnable  = 1'b0;
        memWrite   = 1'b1;
        memRead    = 1'b0;
        memAddrBus = a;
        tbDrive    = 1'b0;
        expQ.push_back(model[a[9:0]]);
        @(posedge clk);
        #1;
        exp = expQ.pop_front();
        checkVal($sformatf("read@%0h", a), 32'(memDataBus), 32'(exp));
    endtask

    task automatic checkStatus(input string tag, input int rc, input int wc, input logic [2:0] fl);
        checkVal({tag, ".readCount"}, 32'(readCount), 32'(rc));
        checkVal({tag, ".writeCount"}, 32'(writeCount), 32'(wc));
        checkVal({tag, ".errorFlags"}, 32'(errorFlags), 32'(fl));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        busIdle();
        rst        = 1'b1;
        memAddrBus = '0;
        tbData     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkStatus("reset", 0, 0, 3'b000);
        checkVal("reset.bus", 32'(memDataBus), 32'hFFFF);

        // Basic write then read back
        writeWord(18'h00005, 16'hBEEF, 2);
        checkVal("wr5.writeCount", 32'(writeCount), 32'd1);
        readCycle(18'h00005);
        idleCycle();
        checkStatus("rd5", 1, 1, 3'b000);
        checkVal("rd5.busRelease", 32'(memDataBus), 32'hFFFF);

        // Preload and burst
        writeWord(18'h003FF, 16'h0F0F, 1);
        for (int i = 0; i < 4; i++) writeWord(18'(i), 16'(16'h1111 * (i + 1)), 1);
        for (int i = 0; i < 4; i++) readCycle(18'(i));
        idleCycle();
        checkVal("burst.busRelease", 32'(memDataBus), 32'hFFFF);
        checkStatus("burst", 2, 6, 3'b000);

        // OE and WE both low: treated as a write, responder stays off the bus
        @(negedge clk);
        memEnable  = 1'b0;
        memWrite   = 1'b0;
        memRead    = 1'b0;
        memAddrBus = 18'h00007;
        tbData     = 16'h00A5;
        tbDrive    = 1'b1;
        @(posedge clk);
        #1;
        checkVal("contention.bus", 32'(memDataBus), 32'h00A5);
        idleCycle();
        checkVal("contention.busRelease", 32'(memDataBus), 32'hFFFF);
        model[7] = 16'h00A5;
        checkStatus("contention", 2, 7, 3'b001);
        readCycle(18'h00007);
        idleCycle();

        // Out-of-window address aliases into storage
        writeWord(18'h20003, 16'hCAFE, 1);
        checkStatus("range", 3, 8, 3'b101);
        readCycle(18'h00003);
        idleCycle();
        checkVal("range.flagsAfterRead", 32'(errorFlags), 32'h5);

        // Address moves mid-write: last address wins
        writeWord(18'h00004, 16'h5A5A, 1);
        driveWrite(18'h00004, 16'h1234);
        driveWrite(18'h00006, 16'h1234);
        idleCycle();
        model[6] = 16'h1234;
        checkStatus("addrMove", 4, 10, 3'b111);
        readCycle(18'h00004);
        readCycle(18'h00006);
        idleCycle();
        checkVal("addrMove.readCount", 32'(readCount), 32'd5);

        // Reset mid-write aborts without committing
        writeWord(18'h00009, 16'h9999, 1);
        driveWrite(18'h00009, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        busIdle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkStatus("rstAbort", 0, 0, 3'b000);
        checkVal("rstAbort.bus", 32'(memDataBus), 32'hFFFF);
        readCycle(18'h00009);
        idleCycle();
        checkVal("rstAbort.readCount", 32'(readCount), 32'd1);

        // Commit proceeds while rd is already requested; READ follows an edge later
        driveWrite(18'h00010, 16'h7777);
        @(negedge clk);
        tbDrive    = 1'b0;
        memWrite   = 1'b1;
        memRead    = 1'b0;
        memEnable  = 1'b0;
        memAddrBus = 18'h00010;
        @(posedge clk);
        #1;
        checkVal("wrToRd.commitEdgeBus", 32'(memDataBus), 32'hFFFF);
        checkVal("wrToRd.writeCount", 32'(writeCount), 32'd1);
        model[16] = 16'h7777;
        expQ.push_back(model[16]);
        @(posedge clk);
        #1;
        checkVal("wrToRd.data", 32'(memDataBus), 32'(expQ.pop_front()));
        idleCycle();
        checkVal("wrToRd.busRelease", 32'(memDataBus), 32'hFFFF);

        // memEnable high masks OE/WE entirely
        @(negedge clk);
        memEnable  = 1'b1;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memAddrBus = 18'h3FFFF;
        tbData     = 16'hDEAD;
        tbDrive    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idleCycle();
        checkStatus("ceHigh", 2, 1, 3'b000);
        readCycle(18'h003FF);
        idleCycle();
        checkStatus("ceHighAfter", 3, 1, 3'b000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
